// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 sequential divider: operand width, FSM
// states and the RISC-V special-case result constants.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [WIDTH-1:0] DIV_ZERO_Q = '1;
  localparam logic [WIDTH-1:0] INT_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit and
// subtract the divisor if it fits, producing one quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   trial;

  // The full {rem, msb} is used for the trial so a remainder with its top bit
  // set (possible with divisors >= 2^(WIDTH-1)) is not truncated before the subtract.
  assign rem_shift = {rem[WIDTH-2:0], dvd_msb};
  assign trial     = {rem, dvd_msb} - {1'b0, divisor};
  assign q_bit     = ~trial[WIDTH];
  assign rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift;

endmodule

// File: rtl/seq_radix2_divider.sv
// Multi-cycle 32-bit divider with RISC-V DIV/DIVU/REM/REMU semantics, one
// quotient bit per clock behind a start/valid handshake.
module seq_radix2_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             valid,
  output logic             div_zero
);

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd, rem, dsr_mag;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;

  logic             a_neg, b_neg, is_zero, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, rem_next;
  logic             q_bit;

  assign a_neg   = is_signed & A[WIDTH-1];
  assign b_neg   = is_signed & B[WIDTH-1];
  assign a_mag   = a_neg ? -A : A;
  assign b_mag   = b_neg ? -B : B;
  assign is_zero = (B == '0);
  assign is_ovf  = is_signed && (A == INT_MIN) && (B == DIV_ZERO_Q);
  assign busy    = (state != IDLE);

  div_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dsr_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !is_zero && !is_ovf) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Special cases resolve in IDLE without ever raising busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q        <= '0;
      R        <= '0;
      valid    <= 1'b0;
      div_zero <= 1'b0;
      dvd      <= '0;
      rem      <= '0;
      dsr_mag  <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_zero) begin
              Q        <= DIV_ZERO_Q;
              R        <= A;
              div_zero <= 1'b1;
              valid    <= 1'b1;
            end else if (is_ovf) begin
              Q        <= INT_MIN;
              R        <= '0;
              div_zero <= 1'b0;
              valid    <= 1'b1;
            end else begin
              dvd     <= a_mag;
              dsr_mag <= b_mag;
              rem     <= '0;
              cnt     <= CNT_W'(WIDTH - 1);
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          Q        <= neg_q ? -dvd : dvd;
          R        <= neg_r ? -rem : rem;
          valid    <= 1'b1;
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_radix2_divider.sv
// Scoreboard bench for seq_radix2_divider: a reference model predicts each
// result and its arrival cycle; a monitor pops and compares on every valid.
module tb_seq_radix2_divider;

  logic        clk, rst_n, start, is_signed;
  logic [31:0] A, B, Q, R;
  logic        busy, valid, div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  seq_radix2_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .R         (R),
    .busy      (busy),
    .valid     (valid),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: SV division truncates toward zero and % takes the dividend's
  // sign, which is exactly the RISC-V rule outside the two special cases.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    e.dz  = 1'b0;
    e.due = 33;
    if (b == 32'h0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.due = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'h0; e.due = 0;
    end else if (s) begin
      e.q = sa / sbv; e.r = sa % sbv;
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check_output("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("quotient", Q, e.q);
        check_output("remainder", R, e.r);
        check_output("div_zero", div_zero, e.dz);
        check_output("valid_cycle", cyc, e.due);
        check_output("busy_at_valid", busy, 1'b0);
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, output exp_t e);
    e = model(a, b, s);
    e.due += cyc + 1;
    sb.push_back(e);
    A = a; B = b; is_signed = s; start = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit   ok;
    exp_t e;
    wait_idle(ok);
    if (!ok) return;
    drive(a, b, s, e);
    @(posedge clk);
    #2;
    start = 1'b0;
    check_output("busy_after_accept", busy, (e.due - cyc) != 0);
  endtask

  task automatic hold_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit   ok;
    exp_t e;
    wait_idle(ok);
    if (!ok) return;
    drive(a, b, s, e);
    @(posedge clk);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) check_output("hold_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check_output("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    #12;
    check_output("reset_q", Q, 32'h0);
    check_output("reset_r", R, 32'h0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_valid", valid, 1'b0);
    check_output("reset_dz", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'd100, 32'd7, 1'b0);
    apply_stimulus(32'hFFFF_FFF9, 32'h2, 1'b1);
    apply_stimulus(32'h7, 32'hFFFF_FFFE, 1'b1);
    apply_stimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    apply_stimulus(32'h1234_5678, 32'h0, 1'b0);
    apply_stimulus(32'h1234_5678, 32'h0, 1'b1);
    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    apply_stimulus(32'h8000_0000, 32'h2, 1'b1);
    drain();

    // Back-to-back: the second start lands in the first result's valid cycle.
    apply_stimulus(32'd100, 32'd7, 1'b0);
    apply_stimulus(32'hFFFF_FFFF, 32'h10, 1'b0);
    drain();

    hold_start(32'd5000, 32'd13, 1'b0);
    drain();
    repeat (40) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> (i * 4);
      apply_stimulus(ra, rb, i[0]);
    end
    drain();

    // Abort mid-CALC: outputs clear asynchronously and no result follows.
    apply_stimulus(32'd100, 32'd7, 1'b0);
    drain();
    apply_stimulus(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_output("abort_q", Q, 32'h0);
    check_output("abort_r", R, 32'h0);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_valid", valid, 1'b0);
    check_output("abort_dz", div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    apply_stimulus(32'd9, 32'd3, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_radix2_divider.md
# seq_radix2_divider

Multi-cycle 32-bit integer divider, the inverse companion to the pipelined Booth/Wallace multiplier in the execute unit's M-extension path. Accepts one dividend/divisor pair per request and produces quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics. Uses a restoring radix-2 datapath at one quotient bit per clock, with a start/valid handshake instead of a fixed-latency pipeline.

## Interface
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only while busy=0.
- is_signed  in  1  1 selects two's-complement operands (DIV/REM); 0 selects unsigned (DIVU/REMU).
- A  in  WIDTH  dividend.
- B  in  WIDTH  divisor.
- Q  out  WIDTH  quotient; holds its value until the next result.
- R  out  WIDTH  remainder; holds its value until the next result.
- busy  out  1  high from the cycle after an accepted start until valid.
- valid  out  1  one-cycle pulse when Q/R are updated.
- div_zero  out  1  qualified by valid; B was 0.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1:
  - Latch operands and sign information.
  - Take magnitudes: when is_signed and the MSB is set, negate the operand.
  - Special cases go straight to the result with busy staying 0:
    - B=0: Q=all ones, R=A, div_zero=1.
    - is_signed, A=0x80000000, B=0xFFFFFFFF: Q=0x80000000, R=0.
  - All other cases: set the partial remainder to 0, set counter=WIDTH-1, go to CALC.
- CALC, each cycle:
  - rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]}; shift dvd left by one.
  - trial = rem_shift - |B| computed at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and the quotient bit is 1; otherwise rem=rem_shift and the bit is 0.
  - The quotient bit shifts into the LSB of dvd, so dvd becomes the quotient.
  - When counter=0, go to FIX; otherwise decrement the counter.
- FIX:
  - Q = dvd, negated if is_signed and sign(A)≠sign(B).
  - R = rem, negated if is_signed and A was negative (remainder takes the dividend's sign).
  - Pulse valid, clear div_zero, go to IDLE.
- start while busy=1 is ignored, with no queueing.
- Inputs are only sampled at acceptance, so they may change freely during CALC.

## Timing
- Reset values: Q=0, R=0, busy=0, valid=0, div_zero=0, state=IDLE.
- Reset mid-operation aborts immediately: state becomes IDLE and no valid is issued for the aborted request.
- Normal latency: start is accepted at edge N.
  - busy is high after N.
  - There are WIDTH CALC edges (N+1..N+32) and one FIX edge (N+33).
  - valid is high during the cycle after edge N+33, and busy falls at the same edge.
  - Total: 34 cycles for WIDTH=32.
- Special-case latency: valid is high the cycle after edge N; busy never rises.
- Back-to-back: start may be asserted in the same cycle valid is high (state is IDLE), giving one result per 34 cycles.
- valid is never asserted for two consecutive cycles from a single request.

## Structure
- Shared package div_pkg:
  - WIDTH default.
  - State enum {IDLE, CALC, FIX}.
  - Constants DIV_ZERO_Q (all ones) and INT_MIN (0x80000000).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, dvd MSB, divisor magnitude.
  - Outputs: next rem and quotient bit.
  - Lets a radix-4 variant chain two instances later.
- Top level holds the FSM, counter, operand registers, sign fix-up and output registers.

## Test plan
- Unsigned 100/7, is_signed=0: valid exactly 34 cycles after start, Q=14, R=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002): Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1). Signed 7/-2: Q=-3, R=1.
- 0x12345678/0 with either signedness: valid 1 cycle after start, Q=0xFFFFFFFF, R=0x12345678, div_zero=1, busy stays 0.
- Signed 0x80000000/0xFFFFFFFF: valid after 1 cycle, Q=0x80000000, R=0. Same operands unsigned: Q=0, R=0x80000000 after 34 cycles.
- Handshake:
  - start=1 held during busy: exactly one result is produced.
  - New start in the valid cycle with 0xFFFFFFFF/0x10 unsigned: second valid 34 cycles later with Q=0x0FFFFFFF, R=0xF.
- rst_n pulsed low at cycle 10 of CALC:
  - All outputs return to 0 asynchronously.
  - No valid follows.
  - A fresh 9/3 request afterwards returns Q=3, R=0.
